// File: rtl/fp_issue_seq_pkg.sv
// Shared OP-FP encodings, FPU operation codes and FSM/decode types for the FPU issue sequencer.
package fp_issue_seq_pkg;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;

    localparam logic [6:0] F7_FADD    = 7'b0000000;
    localparam logic [6:0] F7_FSUB    = 7'b0000100;
    localparam logic [6:0] F7_FMUL    = 7'b0001000;
    localparam logic [6:0] F7_FDIV    = 7'b0001100;
    localparam logic [6:0] F7_FMINMAX = 7'b0010100;
    localparam logic [6:0] F7_FSQRT   = 7'b0101100;
    localparam logic [6:0] F7_FCMP    = 7'b1010000;

    localparam logic [2:0] F3_FMIN    = 3'b000;
    localparam logic [2:0] F3_FMAX    = 3'b001;
    localparam logic [2:0] F3_FEQ     = 3'b010;
    localparam logic [2:0] F3_FLT     = 3'b001;
    localparam logic [2:0] F3_FLE     = 3'b000;

    localparam logic [3:0] F_ALU_OP_ADD     = 4'b0000;
    localparam logic [3:0] F_ALU_OP_SUB     = 4'b0001;
    localparam logic [3:0] F_ALU_OP_MUL     = 4'b0010;
    localparam logic [3:0] F_ALU_OP_MIN     = 4'b0011;
    localparam logic [3:0] F_ALU_OP_MAX     = 4'b0100;
    localparam logic [3:0] F_ALU_OP_EQ      = 4'b0101;
    localparam logic [3:0] F_ALU_OP_LT      = 4'b0110;
    localparam logic [3:0] F_ALU_OP_LE      = 4'b0111;
    localparam logic [3:0] F_ALU_OP_DIV     = 4'b1000;
    localparam logic [3:0] F_ALU_OP_SQRT    = 4'b1001;
    localparam logic [3:0] F_ALU_OP_INVALID = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WB    = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic       is_opfp;
        logic       legal;
        logic [3:0] op;
        logic       is_cmp;
        logic [4:0] rd;
    } fp_dec_t;

    // Compares return an integer result, so they retire to the integer register file.
    function automatic logic is_cmp_op(input logic [3:0] op);
        return (op == F_ALU_OP_EQ) || (op == F_ALU_OP_LT) || (op == F_ALU_OP_LE);
    endfunction

endpackage

// File: rtl/fp_op_decode.sv
// Combinational OP-FP decoder: instruction -> {is_opfp, legal, op, is_cmp, rd}.
module fp_op_decode
    import fp_issue_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit ENABLE_DIV  = 1'b1,
    parameter bit ENABLE_SQRT = 1'b1
) (
    input  logic [XLEN-1:0] instruction,
    output fp_dec_t         dec
);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [2:0] funct3_s;
    logic [4:0] rs2_s;
    logic       unused_rs1_s;
    fp_dec_t    dec_s;

    assign opcode_s     = instruction[6:0];
    assign funct3_s     = instruction[14:12];
    assign rs2_s        = instruction[24:20];
    assign funct7_s     = instruction[31:25];
    assign unused_rs1_s = ^instruction[19:15];

    // Field decode; anything not matched stays illegal with the INVALID op code
    always_comb begin
        dec_s.is_opfp = (opcode_s == OPC_OP_FP);
        dec_s.legal   = 1'b0;
        dec_s.op      = F_ALU_OP_INVALID;
        dec_s.is_cmp  = 1'b0;
        dec_s.rd      = instruction[11:7];
        if (opcode_s == OPC_OP_FP) begin
            case (funct7_s)
                F7_FADD: begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_ADD; end
                F7_FSUB: begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_SUB; end
                F7_FMUL: begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_MUL; end
                F7_FMINMAX: begin
                    case (funct3_s)
                        F3_FMIN: begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_MIN; end
                        F3_FMAX: begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_MAX; end
                        default: begin dec_s.legal = 1'b0; end
                    endcase
                end
                F7_FCMP: begin
                    case (funct3_s)
                        F3_FEQ:  begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_EQ; end
                        F3_FLT:  begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_LT; end
                        F3_FLE:  begin dec_s.legal = 1'b1; dec_s.op = F_ALU_OP_LE; end
                        default: begin dec_s.legal = 1'b0; end
                    endcase
                end
                F7_FDIV: begin
                    if (ENABLE_DIV) begin
                        dec_s.legal = 1'b1;
                        dec_s.op    = F_ALU_OP_DIV;
                    end else begin
                        dec_s.legal = 1'b0;
                    end
                end
                F7_FSQRT: begin
                    if (ENABLE_SQRT && (rs2_s == 5'd0)) begin
                        dec_s.legal = 1'b1;
                        dec_s.op    = F_ALU_OP_SQRT;
                    end else begin
                        dec_s.legal = 1'b0;
                    end
                end
                default: begin dec_s.legal = 1'b0; end
            endcase
            dec_s.is_cmp = dec_s.legal & is_cmp_op(dec_s.op);
        end else begin
            dec_s.legal = 1'b0;
        end
    end

    assign dec = dec_s;

endmodule

// File: rtl/fp_issue_seq.sv
// Issue/stall sequencer for a multi-cycle FPU: start pulse, pipeline stall,
// single write-back pulse and a watchdog that flushes a hung FPU.
module fp_issue_seq
    import fp_issue_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT     = 64,
    parameter bit ENABLE_DIV  = 1'b1,
    parameter bit ENABLE_SQRT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] instruction,
    input  logic            fpu_done,
    output logic            stall,
    output logic            fpu_start,
    output logic [3:0]      fpu_op,
    output logic            fpu_flush,
    output logic            fp_reg_write,
    output logic            int_reg_write,
    output logic [4:0]      wb_rd,
    output logic            illegal_instr,
    output logic            timeout,
    output logic            err_sticky
);

    localparam bit WDOG_EN = (TIMEOUT > 32'sd0);
    localparam int CNT_W   = WDOG_EN ? $clog2(TIMEOUT + 32'sd1) : 32'sd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_EN ? TIMEOUT - 32'sd1 : 32'sd0);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    fp_dec_t          dec_s;
    fsm_state_e       state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s, cnt_inc_s;
    logic [3:0]       op_r;
    logic [4:0]       rd_r;
    logic             cmp_r;
    logic             start_r, flush_r, fp_wr_r, int_wr_r, ill_r, to_r, err_r;
    logic             start_nx_s, flush_nx_s, fp_wr_nx_s, int_wr_nx_s, ill_nx_s, to_nx_s;
    logic             latch_s, stall_s;

    fp_op_decode #(
        .XLEN        (XLEN),
        .ENABLE_DIV  (ENABLE_DIV),
        .ENABLE_SQRT (ENABLE_SQRT)
    ) u_decode (
        .instruction (instruction),
        .dec         (dec_s)
    );

    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1'b1);

    // Next-state, stall and next values of the one-cycle output pulses
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        start_nx_s  = 1'b0;
        flush_nx_s  = 1'b0;
        fp_wr_nx_s  = 1'b0;
        int_wr_nx_s = 1'b0;
        ill_nx_s    = 1'b0;
        to_nx_s     = 1'b0;
        latch_s     = 1'b0;
        stall_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid && dec_s.is_opfp) begin
                    if (dec_s.legal) begin
                        stall_s    = 1'b1;
                        latch_s    = 1'b1;
                        start_nx_s = 1'b1;
                        state_nx_s = ST_ISSUE;
                    end else begin
                        ill_nx_s   = 1'b1;
                    end
                end else begin
                    stall_s = 1'b0;
                end
            end
            ST_ISSUE: begin
                stall_s    = 1'b1;
                cnt_nx_s   = '0;
                state_nx_s = ST_BUSY;
            end
            ST_BUSY: begin
                stall_s  = 1'b1;
                cnt_nx_s = cnt_inc_s;
                // A done arriving on the watchdog's last cycle still completes normally
                if (fpu_done) begin
                    fp_wr_nx_s  = ~cmp_r;
                    int_wr_nx_s = cmp_r;
                    state_nx_s  = ST_WB;
                end else if (WDOG_EN && (cnt_r == CNT_LAST)) begin
                    flush_nx_s = 1'b1;
                    to_nx_s    = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_BUSY;
                end
            end
            ST_WB: begin
                stall_s    = 1'b0;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, watchdog counter, latched operation and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            op_r     <= 4'b0000;
            rd_r     <= 5'd0;
            cmp_r    <= 1'b0;
            start_r  <= 1'b0;
            flush_r  <= 1'b0;
            fp_wr_r  <= 1'b0;
            int_wr_r <= 1'b0;
            ill_r    <= 1'b0;
            to_r     <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            start_r  <= start_nx_s;
            flush_r  <= flush_nx_s;
            fp_wr_r  <= fp_wr_nx_s;
            int_wr_r <= int_wr_nx_s;
            ill_r    <= ill_nx_s;
            to_r     <= to_nx_s;
            err_r    <= err_r | to_nx_s;
            if (latch_s) begin
                op_r  <= dec_s.op;
                rd_r  <= dec_s.rd;
                cmp_r <= dec_s.is_cmp;
            end
        end
    end

    assign stall         = stall_s;
    assign fpu_start     = start_r;
    assign fpu_op        = op_r;
    assign fpu_flush     = flush_r;
    assign fp_reg_write  = fp_wr_r;
    assign int_reg_write = int_wr_r;
    assign wb_rd         = rd_r;
    assign illegal_instr = ill_r;
    assign timeout       = to_r;
    assign err_sticky    = err_r;

endmodule

// File: tb/tb_fp_issue_seq.sv
// Scoreboard bench for fp_issue_seq (TIMEOUT=4, FDIV enabled, FSQRT disabled).
module tb_fp_issue_seq;

    localparam int WD = 4;

    logic        clk = 1'b0;
    logic        rst_n, instr_valid, fpu_done;
    logic [31:0] instruction;
    logic        stall, fpu_start, fpu_flush, fp_reg_write, int_reg_write;
    logic        illegal_instr, timeout, err_sticky;
    logic [3:0]  fpu_op;
    logic [4:0]  wb_rd;

    fp_issue_seq #(.XLEN(32), .TIMEOUT(WD), .ENABLE_DIV(1'b1), .ENABLE_SQRT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instruction(instruction),
        .fpu_done(fpu_done), .stall(stall), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .fpu_flush(fpu_flush), .fp_reg_write(fp_reg_write), .int_reg_write(int_reg_write),
        .wb_rd(wb_rd), .illegal_instr(illegal_instr), .timeout(timeout), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event mask bits: 0 start, 1 fp write, 2 int write, 3 illegal, 4 timeout, 5 flush
    typedef struct {
        int         cyc;
        logic [5:0] mask;
        logic [3:0] op;
        logic [4:0] rd;
    } ev_t;

    typedef struct {
        logic [6:0] f7;
        int         f3;   // -1: any funct3 (rounding mode)
        logic [3:0] op;
        bit         cmp;
    } op_t;

    ev_t  evq[$];
    bit   exp_stall[int];
    op_t  ops[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [4:0] rd);
        logic [4:0] rs1;
        rs1 = 5'($urandom);
        return {f7, rs2, rs1, f3, rd, 7'b1010011};
    endfunction

    function automatic logic [31:0] gen_nonfp();
        logic [31:0] v;
        v = $urandom;
        if (v[6:0] == 7'b1010011) v[2] = 1'b0;
        return v;
    endfunction

    task automatic gen_legal(output logic [31:0] ins, output logic [3:0] op,
                             output logic [4:0] rd, output bit cmp);
        int k;
        logic [2:0] f3;
        k  = $urandom_range(0, ops.size() - 1);
        rd = 5'($urandom);
        f3 = (ops[k].f3 < 0) ? 3'($urandom) : 3'(ops[k].f3);
        ins = mk_instr(ops[k].f7, 5'($urandom), f3, rd);
        op  = ops[k].op;
        cmp = ops[k].cmp;
    endtask

    function automatic logic [31:0] gen_illegal();
        logic [6:0] f7;
        case ($urandom_range(0, 3))
            0: begin
                do f7 = 7'($urandom);
                while (f7 inside {7'h00, 7'h04, 7'h08, 7'h0C, 7'h14, 7'h2C, 7'h50});
                return mk_instr(f7, 5'($urandom), 3'($urandom), 5'($urandom));
            end
            1: return mk_instr(7'b0101100, 5'd0, 3'($urandom), 5'($urandom));
            2: return mk_instr(7'b0010100, 5'($urandom), 3'($urandom_range(2, 7)), 5'($urandom));
            default: return mk_instr(7'b1010000, 5'($urandom), 3'($urandom_range(3, 7)), 5'($urandom));
        endcase
    endfunction

    function automatic logic [31:0] junk();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 1) == 0) ins[6:0] = 7'b1010011;
        return ins;
    endfunction

    task automatic push(input int c, input logic [5:0] m, input logic [3:0] op, input logic [4:0] rd);
        ev_t e;
        e.cyc = c; e.mask = m; e.op = op; e.rd = rd;
        evq.push_back(e);
    endtask

    task automatic drive(input bit v, input logic [31:0] ins, input bit d, input bit s);
        @(posedge clk);
        #1;
        instr_valid = v;
        instruction = ins;
        fpu_done    = d;
        exp_stall[cyc] = s;
    endtask

    // d in 0..3: done in the (d+1)th busy cycle; d >= 4: watchdog fires (d==4 sends a late done)
    task automatic do_legal(input logic [31:0] ins, input logic [3:0] op, input logic [4:0] rd,
                            input bit cmp, input int d);
        int t;
        drive(1'b1, ins, 1'b0, 1'b1);
        t = cyc;
        push(t + 1, 6'b000001, op, rd);
        if (d <= 3) push(t + 3 + d, cmp ? 6'b000100 : 6'b000010, op, rd);
        else        push(t + 2 + WD, 6'b110000, op, rd);
        drive(1'($urandom), junk(), 1'($urandom), 1'b1);
        if (d <= 3) begin
            for (int k = 0; k <= d; k++) drive(1'($urandom), junk(), (k == d), 1'b1);
            drive(1'($urandom), junk(), 1'($urandom), 1'b0);
        end else begin
            for (int k = 0; k < WD; k++) drive(1'($urandom), junk(), 1'b0, 1'b1);
            drive(1'b0, 32'h0, (d == 4), 1'b0);
        end
    endtask

    task automatic do_illegal(input logic [31:0] ins);
        drive(1'b1, ins, 1'($urandom), 1'b0);
        push(cyc + 1, 6'b001000, 4'h0, 5'd0);
    endtask

    // Scoreboard monitor: compares DUT pulses, stall and sticky error against expectations
    always @(negedge clk) begin
        logic [5:0] act, exp;
        logic [3:0] eop;
        logic [4:0] erd;
        if (rst_n === 1'b0) begin
            exp_err = 1'b0;
            check("reset_outputs",
                  32'({stall, fpu_start, fpu_flush, fp_reg_write, int_reg_write,
                       illegal_instr, timeout, err_sticky, fpu_op, wb_rd}), 32'h0);
        end else if (rst_n === 1'b1) begin
            act = {fpu_flush, timeout, illegal_instr, int_reg_write, fp_reg_write, fpu_start};
            exp = 6'b0; eop = 4'h0; erd = 5'd0;
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                check("missed_event", 32'(evq[0].cyc), 32'(cyc));
                void'(evq.pop_front());
            end
            while (evq.size() > 0 && evq[0].cyc == cyc) begin
                exp |= evq[0].mask;
                if (evq[0].mask[2:0] != 3'b0) begin eop = evq[0].op; erd = evq[0].rd; end
                void'(evq.pop_front());
            end
            if (act != 6'b0 || exp != 6'b0) begin
                check("event_mask", 32'(act), 32'(exp));
                if (exp[2:0] != 3'b0) check("fpu_op", 32'(fpu_op), 32'(eop));
                if (exp[2:1] != 2'b0) check("wb_rd", 32'(wb_rd), 32'(erd));
            end
            if (exp[4]) exp_err = 1'b1;
            check("err_sticky", 32'(err_sticky), 32'(exp_err));
            if (exp_stall.exists(cyc)) begin
                check("stall", 32'(stall), 32'(exp_stall[cyc]));
                exp_stall.delete(cyc);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        logic [3:0]  op;
        logic [4:0]  rd;
        bit          cmp;
        ops.push_back('{7'b0000000, -1, 4'b0000, 1'b0});
        ops.push_back('{7'b0000100, -1, 4'b0001, 1'b0});
        ops.push_back('{7'b0001000, -1, 4'b0010, 1'b0});
        ops.push_back('{7'b0010100,  0, 4'b0011, 1'b0});
        ops.push_back('{7'b0010100,  1, 4'b0100, 1'b0});
        ops.push_back('{7'b1010000,  2, 4'b0101, 1'b1});
        ops.push_back('{7'b1010000,  1, 4'b0110, 1'b1});
        ops.push_back('{7'b1010000,  0, 4'b0111, 1'b1});
        ops.push_back('{7'b0001100, -1, 4'b1000, 1'b0});

        rst_n = 1'b0; instr_valid = 1'b0; instruction = 32'h0; fpu_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);

        do_legal(32'h002081D3, 4'b0000, 5'd3, 1'b0, 2);                               // FADD f3
        do_legal(mk_instr(7'b1010000, 5'd2, 3'b001, 5'd5), 4'b0110, 5'd5, 1'b1, 0);    // FLT x5
        do_legal(mk_instr(7'b0001100, 5'd4, 3'b000, 5'd7), 4'b1000, 5'd7, 1'b0, 1);    // FDIV
        do_illegal(mk_instr(7'b0101100, 5'd0, 3'b000, 5'd8));                           // FSQRT off
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        do_legal(mk_instr(7'b0001000, 5'd1, 3'b000, 5'd9), 4'b0010, 5'd9, 1'b0, 5);    // FMUL hang
        do_legal(32'h002081D3, 4'b0000, 5'd3, 1'b0, 1);
        do_legal(mk_instr(7'b0001000, 5'd1, 3'b000, 5'd10), 4'b0010, 5'd10, 1'b0, 3);  // last-cycle done

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: begin
                    gen_legal(ins, op, rd, cmp);
                    do_legal(ins, op, rd, cmp, $urandom_range(0, 5));
                end
                6, 7: do_illegal(gen_illegal());
                8: drive(1'b1, gen_nonfp(), 1'($urandom), 1'b0);
                default: drive(1'b0, $urandom, 1'($urandom), 1'b0);
            endcase
            repeat ($urandom_range(0, 1)) drive(1'b0, $urandom, 1'($urandom), 1'b0);
        end

        // Reset while BUSY drops the operation; a later done must not write back
        drive(1'b1, mk_instr(7'b0000100, 5'd1, 3'b000, 5'd12), 1'b0, 1'b1);
        push(cyc + 1, 6'b000001, 4'b0001, 5'd12);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 rst_n = 1'b0; instr_valid = 1'b0; fpu_done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1; fpu_done = 1'b1; exp_stall[cyc] = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        do_legal(mk_instr(7'b0010100, 5'd1, 3'b001, 5'd13), 4'b0100, 5'd13, 1'b0, 0);

        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        check("events_pending", 32'(evq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
